mlp_stream_loader: RTL and testbench

Sequencer between the AXI4-Stream input stage and the MLP on-chip buffers. It consumes one word at a time from the stream slave's single-word holding register and decodes a layer header. It then routes the following payload words, in fixed order (weights, biases, inputs), to the matching buffer with linear write addresses. It releases each stream word back to the slave only when the buffer side can take it.

---
 rtl/mlp_pkg.sv | 26 ++
 rtl/mlp_stream_loader_if.sv | 38 +++
 rtl/mlp_load_counter.sv | 31 +++
 rtl/mlp_stream_loader.sv | 153 +++++++++++++++
 tb/tb_mlp_stream_loader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// mlp_pkg -- shared state encoding, buffer selects and header field layout (rev 1.0)
`default_nettype none

package mlp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_W_LOAD = 3'd2,
    ST_B_LOAD = 3'd3,
    ST_I_LOAD = 3'd4,
    ST_DRAIN  = 3'd5
  } load_state_t;

  localparam logic [1:0] WR_SEL_WEIGHT = 2'd0;
  localparam logic [1:0] WR_SEL_BIAS   = 2'd1;
  localparam logic [1:0] WR_SEL_INPUT  = 2'd2;

  localparam int N_NEURONS_MSB = 31;
  localparam int N_NEURONS_LSB = 16;
  localparam int N_INPUTS_MSB  = 15;
  localparam int N_INPUTS_LSB  = 0;

endpackage

`default_nettype wire

// File: rtl/mlp_stream_loader_if.sv
// mlp_stream_loader_if -- stream slave, buffer write and status signals of the loader (rev 1.0)
`default_nettype none

interface mlp_stream_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);

  logic                  pi_start;
  logic                  pi_mlp_data_valid;
  logic [DATA_WIDTH-1:0] pi_mlp_data;
  logic                  po_data_read;
  logic                  po_wr_en;
  logic                  pi_wr_ready;
  logic [1:0]            po_wr_sel;
  logic [ADDR_WIDTH-1:0] po_wr_addr;
  logic [DATA_WIDTH-1:0] po_wr_data;
  logic [15:0]           po_n_inputs;
  logic [15:0]           po_n_neurons;
  logic                  po_busy;
  logic                  po_done;
  logic                  po_error;

  modport master (
    input  pi_start, pi_mlp_data_valid, pi_mlp_data, pi_wr_ready,
    output po_data_read, po_wr_en, po_wr_sel, po_wr_addr, po_wr_data,
    output po_n_inputs, po_n_neurons, po_busy, po_done, po_error
  );

  modport slave (
    output pi_start, pi_mlp_data_valid, pi_mlp_data, pi_wr_ready,
    input  po_data_read, po_wr_en, po_wr_sel, po_wr_addr, po_wr_data,
    input  po_n_inputs, po_n_neurons, po_busy, po_done, po_error
  );

endinterface

`default_nettype wire

// File: rtl/mlp_load_counter.sv
// mlp_load_counter -- clearable section counter with terminal-count flag (rev 1.0)
`default_nettype none

module mlp_load_counter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH:0]   limit,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  // limit may equal 2**WIDTH, so compare one bit wider than the count
  assign last = (({1'b0, count} + (WIDTH+1)'(1)) == limit);

endmodule

`default_nettype wire

// File: rtl/mlp_stream_loader.sv
// mlp_stream_loader -- decodes a layer header, then streams weights/biases/inputs into the MLP buffers (rev 1.0)
`default_nettype none

module mlp_stream_loader
  import mlp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic         S_AXIS_ACLK,
  input  logic         S_AXIS_ARESETN,
  mlp_stream_loader_if.master bus
);

  localparam int          CNT_W     = ADDR_WIDTH + 1;
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

  load_state_t           state;
  load_state_t           state_next;
  logic                  in_load;
  logic                  accept;
  logic                  wr_handshake;
  logic [1:0]            sec_sel;
  logic [CNT_W-1:0]      limit;
  logic [CNT_W-1:0]      weight_total;
  logic [ADDR_WIDTH-1:0] sec_count;
  logic                  sec_last;
  logic                  cnt_clear;
  logic                  cnt_enable;
  logic [15:0]           hdr_n_in;
  logic [15:0]           hdr_n_n;
  logic [31:0]           hdr_prod;
  logic                  hdr_bad;

  assign hdr_n_in = bus.pi_mlp_data[N_INPUTS_MSB:N_INPUTS_LSB];
  assign hdr_n_n  = bus.pi_mlp_data[N_NEURONS_MSB:N_NEURONS_LSB];
  assign hdr_prod = 32'(hdr_n_in) * 32'(hdr_n_n);
  assign hdr_bad  = (hdr_n_in == 16'd0) || (hdr_n_n == 16'd0) ||
                    (32'(hdr_n_in) > MAX_WORDS) || (32'(hdr_n_n) > MAX_WORDS) ||
                    (hdr_prod > MAX_WORDS);

  assign wr_handshake = bus.po_wr_en && bus.pi_wr_ready;

  always_comb begin
    in_load = 1'b0;
    accept  = 1'b0;
    sec_sel = WR_SEL_WEIGHT;
    limit   = weight_total;
    case (state)
      ST_HEADER: accept = bus.pi_mlp_data_valid;
      ST_W_LOAD: in_load = 1'b1;
      ST_B_LOAD: begin
        in_load = 1'b1;
        sec_sel = WR_SEL_BIAS;
        limit   = CNT_W'(bus.po_n_neurons);
      end
      ST_I_LOAD: begin
        in_load = 1'b1;
        sec_sel = WR_SEL_INPUT;
        limit   = CNT_W'(bus.po_n_inputs);
      end
      default: ;
    endcase
    // a word may only leave the slave when the write register is free or draining now
    if (in_load) begin
      accept = bus.pi_mlp_data_valid && (!bus.po_wr_en || bus.pi_wr_ready);
    end
  end

  assign bus.po_data_read = accept;

  assign cnt_enable = in_load && accept;
  assign cnt_clear  = ((state == ST_HEADER) && accept) || (cnt_enable && sec_last);

  mlp_load_counter #(.WIDTH(ADDR_WIDTH)) u_counter (
    .clk    (S_AXIS_ACLK),
    .rst_n  (S_AXIS_ARESETN),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .limit  (limit),
    .count  (sec_count),
    .last   (sec_last)
  );

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (bus.pi_start) state_next = ST_HEADER;
      ST_HEADER: if (accept) state_next = hdr_bad ? ST_IDLE : ST_W_LOAD;
      ST_W_LOAD: if (accept && sec_last) state_next = ST_B_LOAD;
      ST_B_LOAD: if (accept && sec_last) state_next = ST_I_LOAD;
      ST_I_LOAD: if (accept && sec_last) state_next = ST_DRAIN;
      ST_DRAIN:  if (wr_handshake) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      bus.po_wr_en     <= 1'b0;
      bus.po_wr_sel    <= '0;
      bus.po_wr_addr   <= '0;
      bus.po_wr_data   <= '0;
      bus.po_n_inputs  <= '0;
      bus.po_n_neurons <= '0;
      bus.po_busy      <= 1'b0;
      bus.po_done      <= 1'b0;
      bus.po_error     <= 1'b0;
      weight_total     <= '0;
    end else begin
      bus.po_done <= (state == ST_DRAIN) && wr_handshake;

      if ((state == ST_IDLE) && bus.pi_start) begin
        bus.po_busy  <= 1'b1;
        bus.po_error <= 1'b0;
      end

      if ((state == ST_DRAIN) && wr_handshake) begin
        bus.po_busy <= 1'b0;
      end

      if ((state == ST_HEADER) && accept) begin
        bus.po_n_inputs  <= hdr_n_in;
        bus.po_n_neurons <= hdr_n_n;
        weight_total     <= CNT_W'(hdr_prod);
        if (hdr_bad) begin
          bus.po_error <= 1'b1;
          bus.po_busy  <= 1'b0;
        end
      end

      if (cnt_enable) begin
        bus.po_wr_en   <= 1'b1;
        bus.po_wr_sel  <= sec_sel;
        bus.po_wr_addr <= sec_count;
        bus.po_wr_data <= bus.pi_mlp_data;
      end else if (wr_handshake) begin
        bus.po_wr_en <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mlp_stream_loader.sv
// tb_mlp_stream_loader -- directed table of layer headers plus backpressure, stray-start and reset sequences (rev 1.0)
`default_nettype none

module tb_mlp_stream_loader;

  localparam int DW = 32;
  localparam int AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mlp_stream_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mlp_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_rec_t;

  typedef struct {
    logic [31:0] header;
    bit          bad;
    int          nin;
    int          nn;
    int          nwrites;
  } vec_t;

  wr_rec_t wq[$];
  int      done_cnt = 0;
  int      n_checks = 0;
  int      n_fail   = 0;
  vec_t    vecs[8];

  always @(negedge clk) begin
    if (rst_n && bus.po_wr_en && bus.pi_wr_ready) begin
      wq.push_back({bus.po_wr_sel, bus.po_wr_addr, bus.po_wr_data});
    end
    if (bus.po_done) done_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data_read"}, 64'(bus.po_data_read), 64'd0);
    chk({tag, "_wr_en"},     64'(bus.po_wr_en),     64'd0);
    chk({tag, "_wr_sel"},    64'(bus.po_wr_sel),    64'd0);
    chk({tag, "_wr_addr"},   64'(bus.po_wr_addr),   64'd0);
    chk({tag, "_wr_data"},   64'(bus.po_wr_data),   64'd0);
    chk({tag, "_n_inputs"},  64'(bus.po_n_inputs),  64'd0);
    chk({tag, "_n_neurons"}, 64'(bus.po_n_neurons), 64'd0);
    chk({tag, "_busy"},      64'(bus.po_busy),      64'd0);
    chk({tag, "_done"},      64'(bus.po_done),      64'd0);
    chk({tag, "_error"},     64'(bus.po_error),     64'd0);
  endtask

  task automatic do_start();
    done_cnt = 0;
    wq.delete();
    bus.pi_start = 1'b1;
    step();
    bus.pi_start = 1'b0;
    chk("busy_after_start", 64'(bus.po_busy), 64'd1);
    chk("error_cleared_by_start", 64'(bus.po_error), 64'd0);
  endtask

  // Present a word, wait (bounded) for it to be consumed, then withdraw it one cycle after.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.pi_mlp_data_valid = 1'b1;
    bus.pi_mlp_data       = w;
    @(negedge clk);
    while (!bus.po_data_read && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("data_read_seen", 64'(bus.po_data_read), 64'd1);
    @(posedge clk);
    #1;
    bus.pi_mlp_data_valid = 1'b0;
  endtask

  task automatic send_payload(input int first, input int last_excl, input logic [31:0] base);
    for (int k = first; k < last_excl; k++) begin
      step();
      send_word(base + 32'(k));
    end
  endtask

  task automatic check_writes(input string tag, input int nin, input int nn, input int nwr,
                              input logic [31:0] base);
    int            nw;
    logic [1:0]    es;
    logic [AW-1:0] ea;
    wr_rec_t       want;
    nw = nin * nn;
    chk({tag, "_write_count"}, 64'(wq.size()), 64'(nwr));
    for (int k = 0; k < nwr && k < wq.size(); k++) begin
      if (k < nw) begin
        es = 2'd0; ea = AW'(k);
      end else if (k < nw + nn) begin
        es = 2'd1; ea = AW'(k - nw);
      end else begin
        es = 2'd2; ea = AW'(k - nw - nn);
      end
      want = '{sel: es, addr: ea, data: base + 32'(k)};
      chk($sformatf("%s_write%0d", tag, k), 64'(wq[k]), 64'(want));
    end
  endtask

  task automatic finish_good(input string tag, input int nin, input int nn, input int nwr,
                             input logic [31:0] base);
    for (int n = 0; n < 300 && bus.po_busy; n++) step();
    chk({tag, "_busy_end"}, 64'(bus.po_busy), 64'd0);
    step();
    step();
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_wr_en_idle"}, 64'(bus.po_wr_en), 64'd0);
    check_writes(tag, nin, nn, nwr, base);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{header: 32'h0002_0003, bad: 1'b0, nin: 3, nn: 2,  nwrites: 11};
    vecs[1] = '{header: 32'h0000_0004, bad: 1'b1, nin: 4, nn: 0,  nwrites: 0};
    vecs[2] = '{header: 32'h0004_0005, bad: 1'b1, nin: 5, nn: 4,  nwrites: 0};
    vecs[3] = '{header: 32'h0004_0004, bad: 1'b0, nin: 4, nn: 4,  nwrites: 24};
    vecs[4] = '{header: 32'h0001_0000, bad: 1'b1, nin: 0, nn: 1,  nwrites: 0};
    vecs[5] = '{header: 32'h0001_0011, bad: 1'b1, nin: 17, nn: 1, nwrites: 0};
    vecs[6] = '{header: 32'h0001_0001, bad: 1'b0, nin: 1, nn: 1,  nwrites: 3};
    vecs[7] = '{header: 32'h0010_0001, bad: 1'b0, nin: 1, nn: 16, nwrites: 33};

    bus.pi_start          = 1'b0;
    bus.pi_mlp_data_valid = 1'b0;
    bus.pi_mlp_data       = '0;
    bus.pi_wr_ready       = 1'b1;

    rst_n = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      string       tag;
      logic [31:0] base;
      tag  = $sformatf("vec%0d", i);
      base = 32'h100 * 32'(i + 1);
      do_start();
      send_word(vecs[i].header);
      if (vecs[i].bad) begin
        chk({tag, "_error_set"}, 64'(bus.po_error), 64'd1);
        chk({tag, "_busy_dropped"}, 64'(bus.po_busy), 64'd0);
        // a word offered while idle must stay in the slave
        bus.pi_mlp_data_valid = 1'b1;
        bus.pi_mlp_data       = 32'hDEAD_0000;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk({tag, "_idle_no_read"}, 64'(bus.po_data_read), 64'd0);
        end
        step();
        bus.pi_mlp_data_valid = 1'b0;
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd0);
        chk({tag, "_write_count"}, 64'(wq.size()), 64'd0);
      end else begin
        chk({tag, "_n_inputs"}, 64'(bus.po_n_inputs), 64'(vecs[i].nin));
        chk({tag, "_n_neurons"}, 64'(bus.po_n_neurons), 64'(vecs[i].nn));
        chk({tag, "_error_clear"}, 64'(bus.po_error), 64'd0);
        send_payload(0, vecs[i].nwrites, base);
        finish_good(tag, vecs[i].nin, vecs[i].nn, vecs[i].nwrites, base);
      end
    end

    // Backpressure during weights: first weight stalls for 5 cycles with the next word waiting.
    do_start();
    send_word(32'h0002_0003);
    step();
    send_word(32'h200);
    bus.pi_wr_ready       = 1'b0;
    bus.pi_mlp_data_valid = 1'b1;
    bus.pi_mlp_data       = 32'h201;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_no_read", 64'(bus.po_data_read), 64'd0);
      chk("bp_hold", 64'({bus.po_wr_en, bus.po_wr_sel, bus.po_wr_addr, bus.po_wr_data}),
          64'({1'b1, 2'd0, 4'd0, 32'h200}));
      @(posedge clk);
      #1;
    end
    bus.pi_wr_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_on_ready", 64'(bus.po_data_read), 64'd1);
    @(posedge clk);
    #1;
    bus.pi_mlp_data_valid = 1'b0;
    chk("bp_next_write", 64'({bus.po_wr_en, bus.po_wr_sel, bus.po_wr_addr, bus.po_wr_data}),
        64'({1'b1, 2'd0, 4'd1, 32'h201}));
    send_payload(2, 11, 32'h200);
    finish_good("bp", 3, 2, 11, 32'h200);

    // Stray start in the middle of the weight section.
    do_start();
    send_word(32'h0002_0003);
    send_payload(0, 3, 32'h300);
    bus.pi_start = 1'b1;
    step();
    bus.pi_start = 1'b0;
    chk("stray_start_busy", 64'(bus.po_busy), 64'd1);
    chk("stray_start_read", 64'(bus.po_data_read), 64'd0);
    send_payload(3, 11, 32'h300);
    finish_good("stray", 3, 2, 11, 32'h300);

    // Reset while weight 4 is on offer, then a clean 1x1 load.
    do_start();
    send_word(32'h0002_0003);
    send_payload(0, 4, 32'h400);
    step();
    bus.pi_mlp_data_valid = 1'b1;
    bus.pi_mlp_data       = 32'h404;
    rst_n                 = 1'b0;
    step();
    bus.pi_mlp_data_valid = 1'b0;
    step();
    check_all_zero("midreset");
    rst_n = 1'b1;
    step();
    do_start();
    send_word(32'h0001_0001);
    chk("after_reset_n_inputs", 64'(bus.po_n_inputs), 64'd1);
    chk("after_reset_n_neurons", 64'(bus.po_n_neurons), 64'd1);
    send_payload(0, 3, 32'h500);
    finish_good("after_reset", 1, 1, 3, 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
